rs_dpram_sched: RTL

//  Sequencer for the RS decoder symbol-delay DP RAM. Stores each received
//  7-bit symbol in the RAM and replays it exactly DELAY accepted symbols

---
 rtl/rs_dpram_sched_if.sv | 50 +++++
 rtl/rs_dpram_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_dpram_sched_if.sv
// Stream, RAM-port and status bundle for the RS decoder symbol-delay sequencer.
// Optional feature macro: RS_DPRAM_SCHED_ERR_EN adds the sticky err_sync status bit.
// master = stream source / RAM + status sink, slave = the sequencer itself.
interface rs_dpram_sched_if;

   logic       enable;
   logic       in_valid;
   logic       sync_in;
   logic       flush;
   logic [6:0] data_in;

   logic       ram_wren;
   logic [7:0] ram_wraddress;
   logic [6:0] ram_data;
   logic       ram_rden;
   logic [7:0] ram_rdaddress;

   logic       out_valid;
   logic       out_sync;
   logic       busy;

`ifdef RS_DPRAM_SCHED_ERR_EN
   logic       err_sync;

   modport master (
      output enable, in_valid, sync_in, flush, data_in,
      input  ram_wren, ram_wraddress, ram_data, ram_rden, ram_rdaddress,
      input  out_valid, out_sync, busy, err_sync
   );

   modport slave (
      input  enable, in_valid, sync_in, flush, data_in,
      output ram_wren, ram_wraddress, ram_data, ram_rden, ram_rdaddress,
      output out_valid, out_sync, busy, err_sync
   );
`else
   modport master (
      output enable, in_valid, sync_in, flush, data_in,
      input  ram_wren, ram_wraddress, ram_data, ram_rden, ram_rdaddress,
      input  out_valid, out_sync, busy
   );

   modport slave (
      input  enable, in_valid, sync_in, flush, data_in,
      output ram_wren, ram_wraddress, ram_data, ram_rden, ram_rdaddress,
      output out_valid, out_sync, busy
   );
`endif

endinterface

// File: rtl/rs_dpram_sched.sv
// Sequencer for the RS decoder symbol-delay dual-port RAM: writes each accepted
// symbol, replays it DELAY accepted symbols later, frames out_sync every CW_LEN
// replayed symbols and drains the buffer on flush.
// Optional feature macro: RS_DPRAM_SCHED_ERR_EN adds a sticky err_sync flag for
// misaligned sync pulses and for symbols presented while draining.
module rs_dpram_sched #(
   parameter int DEPTH  = 143,
   parameter int DELAY  = 140,
   parameter int CW_LEN = 127
) (
   input logic CLK,
   input logic RESET,
   rs_dpram_sched_if.slave bus
);

   localparam logic [7:0] PTR_LAST = 8'(DEPTH - 1);
   localparam logic [7:0] OCC_FULL = 8'(DELAY);
   localparam logic [7:0] CNT_LAST = 8'(CW_LEN - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

   state_t     state_q, state_d;

   logic [7:0] wp_q, wp_d;
   logic [7:0] rp_q, rp_d;
   logic [7:0] occ_q, occ_d;
   logic [7:0] rd_cnt_q, rd_cnt_d;
   logic [7:0] wr_cnt_q, wr_cnt_d;

   logic       ram_wren_q, ram_wren_d;
   logic [7:0] ram_wraddress_q, ram_wraddress_d;
   logic [6:0] ram_data_q, ram_data_d;
   logic       ram_rden_q, ram_rden_d;
   logic [7:0] ram_rdaddress_q, ram_rdaddress_d;

   logic       p1_valid_q, p1_valid_d;
   logic       p1_sync_q, p1_sync_d;
   logic       p2_valid_q, p2_valid_d;
   logic       p2_sync_q, p2_sync_d;
   logic       out_valid_q, out_valid_d;
   logic       out_sync_q, out_sync_d;
   logic       busy_q, busy_d;

   logic       accept;
   logic       start;
   logic       do_read;
   logic [7:0] wr_base;
   logic [7:0] occ_wr;

   function automatic logic [7:0] ptr_inc(input logic [7:0] p);
      return (p == PTR_LAST) ? 8'd0 : p + 8'd1;
   endfunction

   function automatic logic [7:0] cnt_inc(input logic [7:0] c);
      return (c == CNT_LAST) ? 8'd0 : c + 8'd1;
   endfunction

   // A new stream restarts both pointers at 0, so the first write lands at address 0.
   assign accept  = bus.enable & bus.in_valid &
                    (((state_q == IDLE) & bus.sync_in) | (state_q == FILL) | (state_q == RUN));
   assign start   = accept & (state_q == IDLE);
   assign do_read = bus.enable &
                    (((state_q == RUN) & accept) | ((state_q == DRAIN) & (occ_q != 8'd0)));
   assign wr_base = start ? 8'd0 : wp_q;
   assign occ_wr  = start ? 8'd1 : occ_q + 8'd1;

   // State register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: flush wins over the fill-complete transition; a same-cycle symbol is still written.
   always_comb begin
      state_d = state_q;
      if (bus.enable) begin
         case (state_q)
            IDLE:    if (start) state_d = (occ_wr == OCC_FULL) ? RUN : FILL;
            FILL: begin
               if (bus.flush)                           state_d = DRAIN;
               else if (accept && occ_wr == OCC_FULL)   state_d = RUN;
            end
            RUN:     if (bus.flush) state_d = DRAIN;
            DRAIN:   if (occ_q <= 8'd1) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output/datapath: RAM port strobes, pointer and occupancy updates, and the 2-stage replay marker pipe.
   always_comb begin
      wp_d            = wp_q;
      rp_d            = rp_q;
      occ_d           = occ_q;
      rd_cnt_d        = rd_cnt_q;
      wr_cnt_d        = wr_cnt_q;
      ram_wren_d      = 1'b0;
      ram_wraddress_d = ram_wraddress_q;
      ram_data_d      = ram_data_q;
      ram_rden_d      = 1'b0;
      ram_rdaddress_d = ram_rdaddress_q;
      p1_valid_d      = p1_valid_q;
      p1_sync_d       = p1_sync_q;
      p2_valid_d      = p2_valid_q;
      p2_sync_d       = p2_sync_q;
      out_valid_d     = out_valid_q;
      out_sync_d      = out_sync_q;

      if (start) begin
         rp_d     = 8'd0;
         rd_cnt_d = 8'd0;
      end

      if (accept) begin
         ram_wren_d      = 1'b1;
         ram_wraddress_d = wr_base;
         ram_data_d      = bus.data_in;
         wp_d            = ptr_inc(wr_base);
         wr_cnt_d        = cnt_inc(start ? 8'd0 : wr_cnt_q);
         if (state_q != RUN) occ_d = occ_wr;
      end

      if (do_read) begin
         ram_rden_d      = 1'b1;
         ram_rdaddress_d = rp_q;
         rp_d            = ptr_inc(rp_q);
         rd_cnt_d        = cnt_inc(rd_cnt_q);
         if (state_q == DRAIN) occ_d = occ_q - 8'd1;
      end

      if (bus.enable) begin
         p1_valid_d  = do_read;
         p1_sync_d   = do_read & (rd_cnt_q == 8'd0);
         p2_valid_d  = p1_valid_q;
         p2_sync_d   = p1_sync_q;
         out_valid_d = p2_valid_q;
         out_sync_d  = p2_sync_q;
      end

      busy_d = (state_d != IDLE);
   end

   // Datapath and output registers; reset discards any buffered stream.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wp_q            <= 8'd0;
         rp_q            <= 8'd0;
         occ_q           <= 8'd0;
         rd_cnt_q        <= 8'd0;
         wr_cnt_q        <= 8'd0;
         ram_wren_q      <= 1'b0;
         ram_wraddress_q <= 8'd0;
         ram_data_q      <= 7'd0;
         ram_rden_q      <= 1'b0;
         ram_rdaddress_q <= 8'd0;
         p1_valid_q      <= 1'b0;
         p1_sync_q       <= 1'b0;
         p2_valid_q      <= 1'b0;
         p2_sync_q       <= 1'b0;
         out_valid_q     <= 1'b0;
         out_sync_q      <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         wp_q            <= wp_d;
         rp_q            <= rp_d;
         occ_q           <= occ_d;
         rd_cnt_q        <= rd_cnt_d;
         wr_cnt_q        <= wr_cnt_d;
         ram_wren_q      <= ram_wren_d;
         ram_wraddress_q <= ram_wraddress_d;
         ram_data_q      <= ram_data_d;
         ram_rden_q      <= ram_rden_d;
         ram_rdaddress_q <= ram_rdaddress_d;
         p1_valid_q      <= p1_valid_d;
         p1_sync_q       <= p1_sync_d;
         p2_valid_q      <= p2_valid_d;
         p2_sync_q       <= p2_sync_d;
         out_valid_q     <= out_valid_d;
         out_sync_q      <= out_sync_d;
         busy_q          <= busy_d;
      end
   end

`ifdef RS_DPRAM_SCHED_ERR_EN
   logic err_sync_q, err_sync_d;

   // Sticky error: sync seen away from codeword position 0, or a symbol offered while draining.
   always_comb begin
      err_sync_d = err_sync_q;
      if (accept && bus.sync_in && (state_q == FILL || state_q == RUN) && wr_cnt_q != 8'd0)
         err_sync_d = 1'b1;
      if (bus.enable && bus.in_valid && state_q == DRAIN)
         err_sync_d = 1'b1;
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) err_sync_q <= 1'b0;
      else        err_sync_q <= err_sync_d;
   end

   assign bus.err_sync = err_sync_q;
`else
   // Without the error option, misaligned syncs and symbols offered during drain are simply ignored.
`endif

   assign bus.ram_wren      = ram_wren_q;
   assign bus.ram_wraddress = ram_wraddress_q;
   assign bus.ram_data      = ram_data_q;
   assign bus.ram_rden      = ram_rden_q;
   assign bus.ram_rdaddress = ram_rdaddress_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_sync      = out_sync_q;
   assign bus.busy          = busy_q;

endmodule
